fwd_datapath: RTL and testbench
===============================

Name: fwd_datapath

Overview:
- Parametrised X/M/W pipeline datapath for the RV32 core, replacing the fixed 32-bit, forward-less register chain.
- Captures register-file operands into the X stage and forwards in-flight results from the X, M and W stages.
- Carries destination/write-enable control through M and W, and sign/zero-extends load data in M.
- Reports load-use hazards, and accepts stall and flush from the hazard/branch controller.

Parameters:
XLEN, 32, datapath width (32 or 64)
RA_W, 5, register address width
FWD_EN, 1, 1 = forwarding enabled; 0 = operands always taken from reg data inputs

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset; asynchronous assert, active-low
stall_i  in  1  D held by controller; X captures a bubble
flush_i  in  1  kill instructions entering X and M
d_rs1_addr_i  in  RA_W  D-stage source 1 address
d_rs2_addr_i  in  RA_W  D-stage source 2 address
reg1_data_i  in  XLEN  regfile read data 1
reg2_data_i  in  XLEN  regfile read data 2
d_rd_addr_i  in  RA_W  D-stage destination
d_we_i  in  1  D-stage writes rd
d_is_load_i  in  1  D-stage is a load
d_ld_size_i  in  2  0 = byte, 1 = half, 2 = word (3 = dword when XLEN = 64)
d_ld_uns_i  in  1  zero-extend load
arith_out_i  in  XLEN  X-stage ALU result (combinational)
mem_rdata_i  in  XLEN  data memory read data, valid in M
x_arith_op1_o  out  XLEN  X operand 1
x_arith_op2_o  out  XLEN  X operand 2
m_addr_o  out  XLEN  registered ALU result in M (memory address)
w_mux_o  out  XLEN  W-stage writeback data
w_rd_addr_o  out  RA_W  W-stage destination
w_we_o  out  1  W-stage write enable
hazard_o  out  1  load-use hazard, combinational

Behaviour:
- Reset: every register and output is 0; w_we_o = 0; hazard_o = 0 (no valid stages).
- Pipeline registers:
  - X: ops, rd, we, is_load, size, uns.
  - M: alu (= arith_out_i), rd, we, is_load, size, uns.
  - W: mux data, rd, we.
- Each stage advances every cycle unless altered below.
- Operand select at D->X capture, per source, in priority order:
  - (1) X-stage match and X is not a load -> arith_out_i.
  - (2) M-stage match -> M result: extended load data if M is a load, else M alu.
  - (3) W-stage match -> w_mux_o.
  - (4) otherwise the reg data input.
  - A match requires src addr == stage rd, stage we = 1, and rd != 0.
  - Address 0 always yields reg data. FWD_EN = 0 always yields reg data.
- hazard_o = 1 when X is a valid load (we = 1, is_load = 1), X rd != 0, and rd equals either source address.
  - Asserted regardless of FWD_EN. hazard_o is not gated by stall_i.
- stall_i = 1:
  - X captures a bubble (we = 0, is_load = 0); X operand registers hold their old values.
  - M and W advance normally.
- flush_i = 1:
  - X captures a bubble and M captures a bubble (we = 0, is_load = 0).
  - W advances normally.
  - flush_i overrides stall_i.
- Load extension in M, offset = m_addr_o[1:0] (also [2] for XLEN = 64):
  - byte: selects byte at offset.
  - half: selects half at offset[1] (offset[0] ignored).
  - word: selects word at offset[2] when XLEN = 64, otherwise the whole word.
  - Sign-extend from the selected MSB unless uns = 1 (zero-extend).
  - Misalignment is not trapped here.
- W capture: w_mux = extended load if M is_load, else M alu. rd and we are copied from M.
- Latency:
  - ALU result reaches w_mux_o 2 cycles after arith_out_i is sampled.
  - A load reaches w_mux_o 1 cycle after mem_rdata_i.
- Reset mid-operation: all stages are cleared asynchronously; the first instruction after rst_n_i rises sees no forwards.

Test Plan:
- Reset: drive activity, assert rst_n_i mid-cycle -> all outputs 0 immediately; w_we_o = 0.
- Back-to-back ALU dependency:
  - Sequence: add x5 with arith_out_i = 0x0000_0010, then D rs1 = 5 with reg1_data_i = 0xDEAD_BEEF.
  - Required: x_arith_op1_o = 0x10.
  - Same case with FWD_EN = 0: x_arith_op1_o = 0xDEAD_BEEF.
- Priority:
  - Setup: x5 in flight in X (arith_out_i = 1) and M (alu = 2), W carries 3.
  - Required: operand = 1.
  - Remove the X match -> 2; remove the M match -> 3.
  - rd = x0 with we = 1 -> reg data used.
- Load-use:
  - Sequence: lb x7 in X, then D rs2 = 7 -> hazard_o = 1.
  - With stall_i = 1 for one cycle, next cycle mem_rdata_i = 0x0000_8000 and offset 1.
  - Required: x_arith_op2_o = 0xFFFF_FF80, then w_mux_o = 0xFFFF_FF80.
- Extension:
  - lhu at offset 2 with mem_rdata_i = 0x8001_0000 -> w_mux_o = 0x0000_8001.
  - lh at the same offset -> 0xFFFF_8001.
  - lw -> 0x8001_0000.
- Flush:
  - Setup: flush_i = 1 with valid instructions in D and X.
  - Required: 1 and 2 cycles later w_we_o = 0 for both.
  - The instruction already in M still writes.
  - flush_i + stall_i together behave as flush.

Source files
------------

// File: rtl/fwd_datapath_if.sv
// X/M/W datapath bus: D-stage operands and control in, stage results out.
// Signal names follow the core's pipeline port naming.
interface fwd_datapath_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) ();
  logic            stall_i;
  logic            flush_i;
  logic [RA_W-1:0] d_rs1_addr_i;
  logic [RA_W-1:0] d_rs2_addr_i;
  logic [XLEN-1:0] reg1_data_i;
  logic [XLEN-1:0] reg2_data_i;
  logic [RA_W-1:0] d_rd_addr_i;
  logic            d_we_i;
  logic            d_is_load_i;
  logic [1:0]      d_ld_size_i;
  logic            d_ld_uns_i;
  logic [XLEN-1:0] arith_out_i;
  logic [XLEN-1:0] mem_rdata_i;
  logic [XLEN-1:0] x_arith_op1_o;
  logic [XLEN-1:0] x_arith_op2_o;
  logic [XLEN-1:0] m_addr_o;
  logic [XLEN-1:0] w_mux_o;
  logic [RA_W-1:0] w_rd_addr_o;
  logic            w_we_o;
  logic            hazard_o;

  modport slave (
    input  stall_i, flush_i, d_rs1_addr_i, d_rs2_addr_i, reg1_data_i, reg2_data_i,
           d_rd_addr_i, d_we_i, d_is_load_i, d_ld_size_i, d_ld_uns_i,
           arith_out_i, mem_rdata_i,
    output x_arith_op1_o, x_arith_op2_o, m_addr_o, w_mux_o, w_rd_addr_o, w_we_o,
           hazard_o
  );

  modport master (
    output stall_i, flush_i, d_rs1_addr_i, d_rs2_addr_i, reg1_data_i, reg2_data_i,
           d_rd_addr_i, d_we_i, d_is_load_i, d_ld_size_i, d_ld_uns_i,
           arith_out_i, mem_rdata_i,
    input  x_arith_op1_o, x_arith_op2_o, m_addr_o, w_mux_o, w_rd_addr_o, w_we_o,
           hazard_o
  );
endinterface

// File: rtl/fwd_datapath.sv
// X/M/W pipeline datapath with X/M/W operand forwarding and M-stage load extension.
// ALU result reaches W 2 cycles after X; stall bubbles X only, flush bubbles X and M.
module fwd_datapath #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int FWD_EN = 1
) (
  input logic           clk_i,
  input logic           rst_n_i,
  fwd_datapath_if.slave bus
);

  localparam int OFFW = (XLEN == 64) ? 3 : 2;

  // X stage
  logic [XLEN-1:0] r_x_op1;
  logic [XLEN-1:0] r_x_op2;
  logic [RA_W-1:0] r_x_rd;
  logic            r_x_we;
  logic            r_x_is_load;
  logic [1:0]      r_x_size;
  logic            r_x_uns;
  // M stage
  logic [XLEN-1:0] r_m_alu;
  logic [RA_W-1:0] r_m_rd;
  logic            r_m_we;
  logic            r_m_is_load;
  logic [1:0]      r_m_size;
  logic            r_m_uns;
  // W stage
  logic [XLEN-1:0] r_w_mux;
  logic [RA_W-1:0] r_w_rd;
  logic            r_w_we;

  logic [OFFW-1:0] w_off;
  logic [5:0]      w_shamt;
  logic [XLEN-1:0] w_ld_sh;
  logic [XLEN-1:0] w_ld_mask;
  logic            w_ld_sign;
  logic [XLEN-1:0] w_ld_ext;
  logic [XLEN-1:0] w_m_res;
  logic [XLEN-1:0] w_fwd1;
  logic [XLEN-1:0] w_fwd2;

  assign w_off = r_m_alu[OFFW-1:0];

  always_comb begin
    w_shamt = '0;
    case (r_m_size)
      2'd0:    w_shamt = 6'({w_off, 3'b000});
      2'd1:    w_shamt = 6'({w_off[OFFW-1:1], 4'b0000});
      2'd2:    w_shamt = (XLEN == 64) ? 6'({w_off[OFFW-1], 5'b00000}) : 6'd0;
      default: w_shamt = '0;
    endcase
  end

  assign w_ld_sh = bus.mem_rdata_i >> w_shamt;

  always_comb begin
    w_ld_mask = '1;
    w_ld_sign = 1'b0;
    case (r_m_size)
      2'd0: begin
        w_ld_mask = XLEN'(8'hFF);
        w_ld_sign = w_ld_sh[7];
      end
      2'd1: begin
        w_ld_mask = XLEN'(16'hFFFF);
        w_ld_sign = w_ld_sh[15];
      end
      2'd2: begin
        w_ld_mask = XLEN'(32'hFFFF_FFFF);
        w_ld_sign = w_ld_sh[31];
      end
      default: begin
        w_ld_mask = '1;
        w_ld_sign = 1'b0;
      end
    endcase
    if (r_m_uns) w_ld_sign = 1'b0;
  end

  assign w_ld_ext = (w_ld_sh & w_ld_mask) | (~w_ld_mask & {XLEN{w_ld_sign}});
  assign w_m_res  = r_m_is_load ? w_ld_ext : r_m_alu;

  function automatic logic fwd_hit(input logic [RA_W-1:0] src,
                                   input logic [RA_W-1:0] rd,
                                   input logic            we);
    return (FWD_EN != 0) && we && (rd != '0) && (src == rd);
  endfunction

  // A load still in X has no data yet, so it never forwards; older stages are tried instead.
  always_comb begin
    w_fwd1 = bus.reg1_data_i;
    if (fwd_hit(bus.d_rs1_addr_i, r_x_rd, r_x_we && !r_x_is_load)) w_fwd1 = bus.arith_out_i;
    else if (fwd_hit(bus.d_rs1_addr_i, r_m_rd, r_m_we))               w_fwd1 = w_m_res;
    else if (fwd_hit(bus.d_rs1_addr_i, r_w_rd, r_w_we))               w_fwd1 = r_w_mux;

    w_fwd2 = bus.reg2_data_i;
    if (fwd_hit(bus.d_rs2_addr_i, r_x_rd, r_x_we && !r_x_is_load)) w_fwd2 = bus.arith_out_i;
    else if (fwd_hit(bus.d_rs2_addr_i, r_m_rd, r_m_we))               w_fwd2 = w_m_res;
    else if (fwd_hit(bus.d_rs2_addr_i, r_w_rd, r_w_we))               w_fwd2 = r_w_mux;
  end

  // Bubbles keep operands and control fields; only we/is_load are cleared.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_x_op1     <= '0;
      r_x_op2     <= '0;
      r_x_rd      <= '0;
      r_x_we      <= 1'b0;
      r_x_is_load <= 1'b0;
      r_x_size    <= '0;
      r_x_uns     <= 1'b0;
    end else if (bus.flush_i || bus.stall_i) begin
      r_x_we      <= 1'b0;
      r_x_is_load <= 1'b0;
    end else begin
      r_x_op1     <= w_fwd1;
      r_x_op2     <= w_fwd2;
      r_x_rd      <= bus.d_rd_addr_i;
      r_x_we      <= bus.d_we_i;
      r_x_is_load <= bus.d_is_load_i;
      r_x_size    <= bus.d_ld_size_i;
      r_x_uns     <= bus.d_ld_uns_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_m_alu     <= '0;
      r_m_rd      <= '0;
      r_m_we      <= 1'b0;
      r_m_is_load <= 1'b0;
      r_m_size    <= '0;
      r_m_uns     <= 1'b0;
    end else begin
      r_m_alu     <= bus.arith_out_i;
      r_m_rd      <= r_x_rd;
      r_m_we      <= r_x_we && !bus.flush_i;
      r_m_is_load <= r_x_is_load && !bus.flush_i;
      r_m_size    <= r_x_size;
      r_m_uns     <= r_x_uns;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_w_mux <= '0;
      r_w_rd  <= '0;
      r_w_we  <= 1'b0;
    end else begin
      r_w_mux <= w_m_res;
      r_w_rd  <= r_m_rd;
      r_w_we  <= r_m_we;
    end
  end

  assign bus.x_arith_op1_o = r_x_op1;
  assign bus.x_arith_op2_o = r_x_op2;
  assign bus.m_addr_o      = r_m_alu;
  assign bus.w_mux_o       = r_w_mux;
  assign bus.w_rd_addr_o   = r_w_rd;
  assign bus.w_we_o        = r_w_we;
  assign bus.hazard_o      = r_x_we && r_x_is_load && (r_x_rd != '0) &&
                             ((r_x_rd == bus.d_rs1_addr_i) || (r_x_rd == bus.d_rs2_addr_i));

endmodule

// File: tb/tb_fwd_datapath.sv
// Bench for fwd_datapath: forwarding (FWD_EN=1 and 0), hazard, stall/flush, load extension.
// Writebacks are checked against a queue of expected (rd, data) pairs.
module tb_fwd_datapath;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwd_datapath_if #(.XLEN(32), .RA_W(5)) aif ();
  fwd_datapath_if #(.XLEN(32), .RA_W(5)) bif ();

  assign bif.stall_i      = aif.stall_i;
  assign bif.flush_i      = aif.flush_i;
  assign bif.d_rs1_addr_i = aif.d_rs1_addr_i;
  assign bif.d_rs2_addr_i = aif.d_rs2_addr_i;
  assign bif.reg1_data_i  = aif.reg1_data_i;
  assign bif.reg2_data_i  = aif.reg2_data_i;
  assign bif.d_rd_addr_i  = aif.d_rd_addr_i;
  assign bif.d_we_i       = aif.d_we_i;
  assign bif.d_is_load_i  = aif.d_is_load_i;
  assign bif.d_ld_size_i  = aif.d_ld_size_i;
  assign bif.d_ld_uns_i   = aif.d_ld_uns_i;
  assign bif.arith_out_i  = aif.arith_out_i;
  assign bif.mem_rdata_i  = aif.mem_rdata_i;

  fwd_datapath #(.XLEN(32), .RA_W(5), .FWD_EN(1)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(aif.slave)
  );
  fwd_datapath #(.XLEN(32), .RA_W(5), .FWD_EN(0)) u_nofwd (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bif.slave)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] dat;
  } wb_t;

  wb_t sb[$];
  int  total = 0;
  int  bad   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rd, input logic we, input logic ld,
                       input logic [1:0] sz, input logic uns,
                       input logic [4:0] rs1, input logic [31:0] r1,
                       input logic [4:0] rs2, input logic [31:0] r2);
    aif.d_rd_addr_i  = rd;
    aif.d_we_i       = we;
    aif.d_is_load_i  = ld;
    aif.d_ld_size_i  = sz;
    aif.d_ld_uns_i   = uns;
    aif.d_rs1_addr_i = rs1;
    aif.reg1_data_i  = r1;
    aif.d_rs2_addr_i = rs2;
    aif.reg2_data_i  = r2;
  endtask

  task automatic nop();
    drive(5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] dat);
    wb_t e;
    e.rd  = rd;
    e.dat = dat;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    wb_t e;
    if (rst_n && aif.w_we_o === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got rd=%0d dat=%h, none required", aif.w_rd_addr_o, aif.w_mux_o);
      end else begin
        e = sb.pop_front();
        if (aif.w_rd_addr_o !== e.rd || aif.w_mux_o !== e.dat) begin
          bad++;
          $display("FAIL wb_data: got rd=%0d dat=%h, required rd=%0d dat=%h",
                   aif.w_rd_addr_o, aif.w_mux_o, e.rd, e.dat);
        end
      end
    end
  end

  task automatic test_reset();
    logic [134:0] outs;
    #2;
    outs = {aif.x_arith_op1_o, aif.x_arith_op2_o, aif.m_addr_o, aif.w_mux_o,
            aif.w_rd_addr_o, aif.w_we_o, aif.hazard_o};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_init: got %h, required 0", outs); end
    #1 rst_n = 1'b1;
    step();
    drive(5'd5, 1'b1, 1'b0, 2'd0, 1'b0, 5'd1, 32'h1111_1111, 5'd2, 32'h2222_2222);
    step();
    aif.arith_out_i = 32'h55;
    drive(5'd6, 1'b1, 1'b0, 2'd0, 1'b0, 5'd3, 32'h3333_3333, 5'd4, 32'h4444_4444);
    step();
    total++;
    if (aif.m_addr_o !== 32'h55) begin bad++; $display("FAIL pre_reset_m: got %h, required 55", aif.m_addr_o); end
    #3 rst_n = 1'b0;
    #1;
    outs = {aif.x_arith_op1_o, aif.x_arith_op2_o, aif.m_addr_o, aif.w_mux_o,
            aif.w_rd_addr_o, aif.w_we_o, aif.hazard_o};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_mid: got %h, required 0", outs); end
    drive(5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd5, 32'hAAAA_0001, 5'd6, 32'hBBBB_0002);
    #2 rst_n = 1'b1;
    step();
    total++;
    if (aif.x_arith_op1_o !== 32'hAAAA_0001 || aif.x_arith_op2_o !== 32'hBBBB_0002) begin
      bad++;
      $display("FAIL reset_nofwd: got %h/%h, required aaaa0001/bbbb0002", aif.x_arith_op1_o, aif.x_arith_op2_o);
    end
    nop();
    step();
  endtask

  task automatic test_back_to_back();
    drive(5'd5, 1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
    step();
    aif.arith_out_i = 32'h10;
    push(5'd5, 32'h10);
    drive(5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0);
    step();
    total++;
    if (aif.x_arith_op1_o !== 32'h10) begin bad++; $display("FAIL b2b_fwd: got %h, required 10", aif.x_arith_op1_o); end
    total++;
    if (bif.x_arith_op1_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL b2b_nofwd: got %h, required deadbeef", bif.x_arith_op1_o); end
    nop();
    step();
    total++;
    if (aif.w_we_o !== 1'b1 || aif.w_mux_o !== 32'h10) begin
      bad++;
      $display("FAIL alu_latency: got we=%b dat=%h, required we=1 dat=10", aif.w_we_o, aif.w_mux_o);
    end
    step();
  endtask

  task automatic test_priority();
    logic [4:0]  rd1 [5] = '{5'd5, 5'd5, 5'd5, 5'd6, 5'd0};
    logic [4:0]  rd2 [5] = '{5'd5, 5'd5, 5'd6, 5'd6, 5'd0};
    logic [4:0]  rd3 [5] = '{5'd5, 5'd6, 5'd6, 5'd6, 5'd0};
    logic [4:0]  src [5] = '{5'd5, 5'd5, 5'd5, 5'd5, 5'd0};
    logic [31:0] ex1 [5] = '{32'd1, 32'd2, 32'd3, 32'h99, 32'h99};
    logic [31:0] ex2 [5] = '{32'd1, 32'd2, 32'd3, 32'h77, 32'h77};
    for (int v = 0; v < 5; v++) begin
      drive(rd1[v], 1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
      step();
      aif.arith_out_i = 32'd3;
      push(rd1[v], 32'd3);
      drive(rd2[v], 1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
      step();
      aif.arith_out_i = 32'd2;
      push(rd2[v], 32'd2);
      drive(rd3[v], 1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
      step();
      aif.arith_out_i = 32'd1;
      push(rd3[v], 32'd1);
      drive(5'd0, 1'b0, 1'b0, 2'd0, 1'b0, src[v], 32'h99, src[v], 32'h77);
      step();
      total++;
      if (aif.x_arith_op1_o !== ex1[v] || aif.x_arith_op2_o !== ex2[v]) begin
        bad++;
        $display("FAIL prio_v%0d: got %h/%h, required %h/%h", v, aif.x_arith_op1_o, aif.x_arith_op2_o, ex1[v], ex2[v]);
      end
      total++;
      if (bif.x_arith_op1_o !== 32'h99) begin
        bad++;
        $display("FAIL prio_nofwd_v%0d: got %h, required 99", v, bif.x_arith_op1_o);
      end
      nop();
      repeat (3) step();
    end
  endtask

  task automatic test_load_use();
    drive(5'd7, 1'b1, 1'b1, 2'd0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
    step();
    aif.arith_out_i = 32'h1001;
    drive(5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 5'd7, 32'h1234);
    #1;
    total++;
    if (aif.hazard_o !== 1'b1 || bif.hazard_o !== 1'b1) begin
      bad++;
      $display("FAIL hazard_set: got %b/%b, required 1/1", aif.hazard_o, bif.hazard_o);
    end
    aif.stall_i = 1'b1;
    step();
    total++;
    if (aif.hazard_o !== 1'b0 || aif.m_addr_o !== 32'h1001) begin
      bad++;
      $display("FAIL stall_bubble: got hz=%b addr=%h, required hz=0 addr=1001", aif.hazard_o, aif.m_addr_o);
    end
    aif.stall_i = 1'b0;
    aif.mem_rdata_i = 32'h0000_8000;
    push(5'd7, 32'hFFFF_FF80);
    step();
    total++;
    if (aif.x_arith_op2_o !== 32'hFFFF_FF80) begin
      bad++;
      $display("FAIL ld_fwd: got %h, required ffffff80", aif.x_arith_op2_o);
    end
    total++;
    if (bif.x_arith_op2_o !== 32'h1234) begin
      bad++;
      $display("FAIL ld_nofwd: got %h, required 1234", bif.x_arith_op2_o);
    end
    total++;
    if (aif.w_mux_o !== 32'hFFFF_FF80) begin
      bad++;
      $display("FAIL ld_wb: got %h, required ffffff80", aif.w_mux_o);
    end
    nop();
    repeat (2) step();
  endtask

  task automatic test_extension();
    logic [1:0]  sz  [6] = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1};
    logic        uns [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] adr [6] = '{32'h102, 32'h102, 32'h102, 32'h103, 32'h103, 32'h103};
    logic [31:0] rd  [6] = '{32'h8001_0000, 32'h8001_0000, 32'h8001_0000,
                             32'h8000_0000, 32'h8000_0000, 32'h8001_0000};
    logic [31:0] exp [6] = '{32'h0000_8001, 32'hFFFF_8001, 32'h8001_0000,
                             32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001};
    for (int i = 0; i < 6; i++) begin
      drive(5'd9, 1'b1, 1'b1, sz[i], uns[i], 5'd0, 32'h0, 5'd0, 32'h0);
      step();
      aif.arith_out_i = adr[i];
      nop();
      step();
      aif.mem_rdata_i = rd[i];
      push(5'd9, exp[i]);
      step();
    end
    repeat (2) step();
  endtask

  task automatic test_flush();
    for (int it = 0; it < 2; it++) begin
      drive(5'd10, 1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
      step();
      aif.arith_out_i = 32'hA;
      push(5'd10, 32'hA);
      drive(5'd11, 1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
      step();
      aif.arith_out_i = 32'hB;
      drive(5'd12, 1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
      aif.flush_i = 1'b1;
      aif.stall_i = (it == 1);
      step();
      aif.flush_i = 1'b0;
      aif.stall_i = 1'b0;
      nop();
      total++;
      if (aif.w_we_o !== 1'b1 || aif.w_rd_addr_o !== 5'd10) begin
        bad++;
        $display("FAIL flush_m_kept_%0d: got we=%b rd=%0d, required we=1 rd=10", it, aif.w_we_o, aif.w_rd_addr_o);
      end
      step();
      total++;
      if (aif.w_we_o !== 1'b0) begin bad++; $display("FAIL flush_x_%0d: got we=%b, required 0", it, aif.w_we_o); end
      step();
      total++;
      if (aif.w_we_o !== 1'b0) begin bad++; $display("FAIL flush_d_%0d: got we=%b, required 0", it, aif.w_we_o); end
      step();
    end
  endtask

  initial begin
    aif.stall_i = 1'b0;
    aif.flush_i = 1'b0;
    aif.arith_out_i = '0;
    aif.mem_rdata_i = '0;
    nop();
    test_reset();
    test_back_to_back();
    test_priority();
    test_load_use();
    test_extension();
    test_flush();
    repeat (2) step();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL wb_missing: got %0d pending, required 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
